// File: rtl/uart_txrx.sv
// 8N1 UART transmitter and receiver sharing one system clock and an external baud square wave.
// Bit edges follow ticker rises (TX); samples are taken on ticker falls (RX, mid-bit).
`timescale 1ps/1ps

module uart_txrx #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ticker,
    input  logic                 read_enable,
    input  logic [DATA_BITS-1:0] bus_value,
    output logic                 signal,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 tx_busy,
    output logic                 rx_valid,
    output logic                 frame_err
);

    localparam int unsigned CntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(DATA_BITS - 1);

    localparam logic [2:0] TxIdle  = 3'd0;
    localparam logic [2:0] TxWait  = 3'd1;
    localparam logic [2:0] TxStart = 3'd2;
    localparam logic [2:0] TxData  = 3'd3;
    localparam logic [2:0] TxStop  = 3'd4;

    localparam logic [1:0] RxIdle = 2'd0;
    localparam logic [1:0] RxData = 2'd1;
    localparam logic [1:0] RxStop = 2'd2;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [1:0] tick_sync_q;
    logic       tick_dly_q;
    logic [1:0] re_sync_q;
    logic       re_dly_q;
    logic [1:0] rx_sync_q;

    logic tick_rise;
    logic tick_fall;
    logic load;
    logic rx_bit;

    // Strobe and line synchronisers reset to their idle-high level so release never fakes an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_sync_q <= 2'b00;
            tick_dly_q  <= 1'b0;
            re_sync_q   <= 2'b11;
            re_dly_q    <= 1'b1;
            rx_sync_q   <= 2'b11;
        end else begin
            tick_sync_q <= {tick_sync_q[0], ticker};
            tick_dly_q  <= tick_sync_q[1];
            re_sync_q   <= {re_sync_q[0], read_enable};
            re_dly_q    <= re_sync_q[1];
            rx_sync_q   <= {rx_sync_q[0], serial_in};
        end
    end

    assign tick_rise = tick_sync_q[1] & ~tick_dly_q;
    assign tick_fall = ~tick_sync_q[1] & tick_dly_q;
    assign load      = re_dly_q & ~re_sync_q[1];
    assign rx_bit    = rx_sync_q[1];

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [2:0]           tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [CntW-1:0]      tx_idx_q, tx_idx_d;
    logic                 signal_q, signal_d;
    logic                 tx_busy_q, tx_busy_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_idx_d   = tx_idx_q;
        signal_d   = signal_q;
        tx_busy_d  = tx_busy_q;
        case (tx_state_q)
            TxIdle: begin
                if (load) begin
                    tx_shift_d = bus_value;
                    tx_busy_d  = 1'b1;
                    tx_state_d = TxWait;
                end
            end
            TxWait: begin
                if (tick_rise) begin
                    signal_d   = 1'b0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tick_rise) begin
                    signal_d   = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_idx_d   = '0;
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                if (tick_rise) begin
                    if (tx_idx_q == LastIdx) begin
                        signal_d   = 1'b1;
                        tx_state_d = TxStop;
                    end else begin
                        signal_d   = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_idx_d   = tx_idx_q + CntW'(1);
                    end
                end
            end
            TxStop: begin
                if (tick_rise) begin
                    tx_busy_d  = 1'b0;
                    tx_state_d = TxIdle;
                end
            end
            default: begin
                signal_d   = 1'b1;
                tx_busy_d  = 1'b0;
                tx_state_d = TxIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TxIdle;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
            signal_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_idx_q   <= tx_idx_d;
            signal_q   <= signal_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    assign signal  = signal_q;
    assign tx_busy = tx_busy_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]           rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_cnt_d    = rx_cnt_q;
        data_out_d  = data_out_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (tick_fall && !rx_bit) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxData;
                end
            end
            RxData: begin
                if (tick_fall) begin
                    // LSB arrives first, so new bits enter at the top and drift down.
                    rx_shift_d = {rx_bit, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_cnt_q == LastIdx) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CntW'(1);
                    end
                end
            end
            RxStop: begin
                if (tick_fall) begin
                    if (rx_bit) begin
                        data_out_d = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    rx_state_d = RxIdle;
                end
            end
            default: begin
                rx_state_d = RxIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q  <= RxIdle;
            rx_shift_q  <= '0;
            rx_cnt_q    <= '0;
            data_out_q  <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_shift_q  <= rx_shift_d;
            rx_cnt_q    <= rx_cnt_d;
            data_out_q  <= data_out_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data_out  = data_out_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Loopback bench for uart_txrx: a per-ticker-period model of the serial line, busy flag
// and expected receive events, checked every clock, plus literal spot checks.
`timescale 1ps/1ps

module tb_uart_txrx;

    localparam int NPER = 1024;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       ticker = 1'b0;
    logic       read_enable = 1'b1;
    logic [7:0] bus_value = 8'h00;
    logic       signal;
    logic       serial_in;
    logic [7:0] data_out;
    logic       tx_busy;
    logic       rx_valid;
    logic       frame_err;
    logic       force_low = 1'b0;

    assign serial_in = signal & ~force_low;

    uart_txrx #(.DATA_BITS(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ticker     (ticker),
        .read_enable(read_enable),
        .bus_value  (bus_value),
        .signal     (signal),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .tx_busy    (tx_busy),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err)
    );

    always #50 clock = ~clock;

    // Ticker period 2000 ps; tper counts ticker periods, bumped at each rise.
    int tper = 0;
    initial begin
        #1025;
        forever begin
            ticker = 1'b1;
            tper   = tper + 1;
            #1000;
            ticker = 1'b0;
            #1000;
        end
    end

    // Model state
    bit         exp_line[NPER];
    bit         exp_busy[NPER];
    int         busy_end = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] q_data[$];
    int         q_per[$];
    bit         q_err[$];

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_ferr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A frame loaded in the second half of period p occupies periods p+1 (start) .. p+10 (stop).
    task automatic model_load(input logic [7:0] b, input bit stop_forced);
        int p;
        p = tper;
        if (p >= busy_end && p + 11 < NPER) begin
            exp_line[p+1] = 1'b0;
            for (int i = 0; i < 8; i++) exp_line[p+2+i] = b[i];
            exp_line[p+10] = 1'b1;
            for (int q = p + 1; q <= p + 10; q++) exp_busy[q] = 1'b1;
            busy_end = p + 11;
            q_data.push_back(b);
            q_per.push_back(p + 10);
            q_err.push_back(stop_forced);
        end
    endtask

    task automatic model_reset();
        last_good = 8'h00;
        q_data.delete();
        q_per.delete();
        q_err.delete();
        busy_end = 0;
        for (int q = tper + 1; q < NPER; q++) begin
            exp_line[q] = 1'b1;
            exp_busy[q] = 1'b0;
        end
    endtask

    task automatic wait_periods(input int n);
        repeat (n) @(negedge ticker);
    endtask

    task automatic pulse_load(input logic [7:0] b, input int hold, input bit stop_forced);
        @(negedge ticker);
        #300;
        bus_value   = b;
        read_enable = 1'b0;
        model_load(b, stop_forced);
        repeat (hold) @(posedge clock);
        #1;
        read_enable = 1'b1;
    endtask

    // Compare process
    logic tick_prev = 1'b0;
    always @(negedge clock) begin
        if (tick_prev && !ticker && tper < NPER) begin
            check("signal_midbit", {31'b0, signal}, {31'b0, exp_line[tper]});
            check("tx_busy_midbit", {31'b0, tx_busy}, {31'b0, exp_busy[tper]});
        end
        tick_prev <= ticker;
        if (rx_valid || frame_err) begin
            if (q_data.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL rx_event: unexpected pulse valid=%0b err=%0b data=%0h", rx_valid,
                         frame_err, data_out);
            end else begin
                logic [7:0] d;
                int         p;
                bit         e;
                d = q_data.pop_front();
                p = q_per.pop_front();
                e = q_err.pop_front();
                if (!e) last_good = d;
                check("rx_kind", {30'b0, rx_valid, frame_err}, e ? 32'd1 : 32'd2);
                check("rx_period", tper, p);
            end
        end
        if (rx_valid) n_valid = n_valid + 1;
        if (frame_err) n_ferr = n_ferr + 1;
        check("data_out", {24'b0, data_out}, {24'b0, last_good});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq[5];
        logic [9:0] a5_seq;
        logic [7:0] b;
        seq    = '{8'h0C, 8'h2D, 8'h09, 8'h43, 8'h65};
        a5_seq = 10'b1101001010;
        for (int q = 0; q < NPER; q++) begin
            exp_line[q] = 1'b1;
            exp_busy[q] = 1'b0;
        end

        // Reset
        #10 reset_n = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("rst_signal", {31'b0, signal}, 32'd1);
        check("rst_data_out", {24'b0, data_out}, 32'h00);
        check("rst_tx_busy", {31'b0, tx_busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("post_rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("post_rst_frame_err", {31'b0, frame_err}, 32'd0);
        check("post_rst_signal", {31'b0, signal}, 32'd1);

        // Loopback sequence, one load per 16 ticker periods
        foreach (seq[i]) begin
            pulse_load(seq[i], 4, 1'b0);
            wait_periods(15);
        end
        check("seq_last_byte", {24'b0, data_out}, 32'h65);
        check("seq_valid_count", n_valid, 32'd5);
        check("seq_ferr_count", n_ferr, 32'd0);

        // 0xA5 bit pattern on the line, one bit per ticker period
        pulse_load(8'hA5, 4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge ticker);
            #300;
            check("a5_bit", {31'b0, signal}, {31'b0, a5_seq[i]});
        end
        wait_periods(5);
        check("a5_received", {24'b0, data_out}, 32'hA5);

        // Second load while busy is ignored
        pulse_load(8'h3C, 4, 1'b0);
        wait_periods(3);
        pulse_load(8'hC3, 4, 1'b0);
        wait_periods(12);
        check("busy_load_ignored", {24'b0, data_out}, 32'h3C);
        check("busy_valid_count", n_valid, 32'd7);

        // Holding read_enable low past the frame does not retrigger
        pulse_load(8'h5A, 280, 1'b0);
        wait_periods(2);
        check("hold_low_byte", {24'b0, data_out}, 32'h5A);
        check("hold_low_valid_count", n_valid, 32'd8);

        // Stop bit forced low
        pulse_load(8'h96, 4, 1'b1);
        wait_periods(9);
        @(posedge ticker);
        #300 force_low = 1'b1;
        @(negedge ticker);
        #500 force_low = 1'b0;
        wait_periods(5);
        check("ferr_data_held", {24'b0, data_out}, 32'h5A);
        check("ferr_count", n_ferr, 32'd1);

        // Reset mid-frame
        pulse_load(8'hE7, 4, 1'b0);
        wait_periods(4);
        #300;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_signal", {31'b0, signal}, 32'd1);
        check("midrst_tx_busy", {31'b0, tx_busy}, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        wait_periods(2);
        pulse_load(8'h71, 4, 1'b0);
        wait_periods(15);
        check("after_rst_byte", {24'b0, data_out}, 32'h71);

        // Random bytes, gaps and strobe widths
        repeat (12) begin
            b = 8'($urandom);
            pulse_load(b, $urandom_range(2, 30), 1'b0);
            wait_periods($urandom_range(4, 15));
        end
        wait_periods(12);
        check("rx_pending", q_data.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
